if_stage: RTL and testbench

//  Instruction-fetch stage: holds the PC and looks up a direct-mapped instruction cache.
//  On a miss it fetches one word through the memory-controller handshake.

---
 rtl/if_stage.sv | 156 +++++++++++++++
 tb/tb_if_stage.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch: PC, direct-mapped I-cache, 2-bit BHT prediction.
// Misses fill one word through a level req / pulse ready handshake.
module if_stage #(
  parameter int ICACHE_IDX_W = 7,
  parameter int BHT_IDX_W    = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [5:0]  stall_in,
  input  logic        jump_enable,
  input  logic [31:0] jump_addr,
  input  logic        bp_update_en,
  input  logic [31:0] bp_update_pc,
  input  logic        bp_update_taken,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_inst,
  output logic        if_stall_req,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        branch_taken_out
);

  localparam int TAG_W = 32 - ICACHE_IDX_W - 2;
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int BHT_N = 1 << BHT_IDX_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [31:0]      pc;
  logic [0:0]       state;
  logic [LINES-1:0] valid;
  logic [31:0]      data_mem [LINES];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [1:0]       bht      [BHT_N];

  logic [ICACHE_IDX_W-1:0] idx;
  logic [ICACHE_IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0]        tag;
  logic [TAG_W-1:0]        fill_tag;
  logic [BHT_IDX_W-1:0]    bht_idx;
  logic [BHT_IDX_W-1:0]    upd_idx;
  logic [31:0]             word;
  logic                    hit;
  logic                    is_br;
  logic                    is_jal;
  logic                    br_pred;
  logic [31:0]             imm_b;
  logic [31:0]             imm_j;
  logic [31:0]             next_pc;
  logic                    pred;
  logic                    fill;
  logic                    unused_bits;

  assign idx      = pc[ICACHE_IDX_W+1:2];
  assign tag      = pc[31:ICACHE_IDX_W+2];
  assign fill_idx = mem_addr[ICACHE_IDX_W+1:2];
  assign fill_tag = mem_addr[31:ICACHE_IDX_W+2];
  assign bht_idx  = pc[BHT_IDX_W+1:2];
  assign upd_idx  = bp_update_pc[BHT_IDX_W+1:2];

  assign word = data_mem[idx];
  assign hit  = valid[idx] && (tag_mem[idx] == tag);

  assign is_br   = word[6:0] == OP_BR;
  assign is_jal  = word[6:0] == OP_JAL;
  assign br_pred = is_br && bht[bht_idx][1];

  assign imm_b = {{19{word[31]}}, word[31], word[7],
                  word[30:25], word[11:8], 1'b0};
  assign imm_j = {{11{word[31]}}, word[31], word[19:12],
                  word[20], word[30:21], 1'b0};

  always_comb begin
    next_pc = pc + 32'd4;
    pred    = 1'b0;
    unique case (1'b1)
      br_pred: begin
        next_pc = pc + imm_b;
        pred    = 1'b1;
      end
      is_jal: begin
        next_pc = pc + imm_j;
        pred    = 1'b1;
      end
      default: ;
    endcase
  end

  assign if_stall_req     = ~hit;
  assign pc_out           = pc;
  assign inst_out         = hit ? word : 32'd0;
  assign branch_taken_out = hit & pred;

  assign fill = rdy_in && (state == S_WAIT) && mem_ready;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc       <= 32'd0;
      state    <= S_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= 32'd0;
      valid    <= '0;
      for (int i = 0; i < BHT_N; i++)
        bht[i] <= 2'b01;
    end else if (rdy_in) begin
      if (jump_enable)
        pc <= jump_addr;
      else if (!stall_in[0] && hit)
        pc <= next_pc;

      unique case (state)
        S_IDLE: begin
          if (!hit && !jump_enable) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // fill targets the request address, even if pc was redirected
          if (mem_ready) begin
            valid[fill_idx] <= 1'b1;
            mem_req         <= 1'b0;
            state           <= S_IDLE;
          end
        end
      endcase

      if (bp_update_en) begin
        if (bp_update_taken && bht[upd_idx] != 2'b11)
          bht[upd_idx] <= bht[upd_idx] + 2'b01;
        else if (!bp_update_taken && bht[upd_idx] != 2'b00)
          bht[upd_idx] <= bht[upd_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && fill) begin
      data_mem[fill_idx] <= mem_inst;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

  assign unused_bits = ^{stall_in[5:1],
                         bp_update_pc[31:BHT_IDX_W+2],
                         bp_update_pc[1:0]};

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: cache fill, prediction, redirects,
// freeze and reset behaviour against a small latency-3 memory model.
module tb_if_stage;

  localparam int LAT = 3;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [5:0]  stall_in;
  logic        jump_enable;
  logic [31:0] jump_addr;
  logic        bp_update_en;
  logic [31:0] bp_update_pc;
  logic        bp_update_taken;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_inst;
  logic        if_stall_req;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        branch_taken_out;

  int total = 0;
  int bad   = 0;
  int cnt   = 0;
  bit auto_mem = 1;

  if_stage dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .stall_in(stall_in),
    .jump_enable(jump_enable),
    .jump_addr(jump_addr),
    .bp_update_en(bp_update_en),
    .bp_update_pc(bp_update_pc),
    .bp_update_taken(bp_update_taken),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ready(mem_ready),
    .mem_inst(mem_inst),
    .if_stall_req(if_stall_req),
    .pc_out(pc_out),
    .inst_out(inst_out),
    .branch_taken_out(branch_taken_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00100093;
      32'h10:  return 32'h00000463;
      32'h20:  return 32'hFF1FF06F;
      32'h40:  return 32'h00500113;
      default: return 32'h00000013;
    endcase
  endfunction

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
    if (auto_mem) begin
      if (mem_ready) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else if (mem_req) begin
        cnt++;
        if (cnt == LAT) begin
          mem_ready = 1'b1;
          mem_inst  = mem_word(mem_addr);
        end
      end
    end
  endtask

  task automatic jump_to(input logic [31:0] a);
    jump_enable = 1'b1;
    jump_addr   = a;
    step();
    jump_enable = 1'b0;
  endtask

  task automatic wait_hit(input string nm);
    int c = 0;
    while (if_stall_req && c < 40) begin
      step();
      c++;
    end
    total++;
    if (if_stall_req) begin
      bad++;
      $display("FAIL %s_timeout stall=%b exp=0", nm, if_stall_req);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step();
    step();
    total++;
    if (if_stall_req !== 1'b1) begin
      bad++;
      $display("FAIL rst_stall got=%b exp=1", if_stall_req);
    end
    total++;
    if ({mem_req, mem_addr} !== 33'd0) begin
      bad++;
      $display("FAIL rst_mem got=%b/%h exp=0/0", mem_req, mem_addr);
    end
    total++;
    if ({pc_out, inst_out, branch_taken_out} !== 65'd0) begin
      bad++;
      $display("FAIL rst_out got=%h/%h/%b exp=0", pc_out, inst_out,
               branch_taken_out);
    end
    rst_in = 1'b0;
  endtask

  task automatic test_cold_start();
    int c = 0;
    int req = 0;
    step();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL cold_req got=%b/%h exp=1/0", mem_req, mem_addr);
    end
    while (if_stall_req && c < 40) begin
      if (mem_req) req++;
      step();
      c++;
    end
    total++;
    if (req != LAT) begin
      bad++;
      $display("FAIL cold_req_cycles got=%0d exp=%0d", req, LAT);
    end
    total++;
    if (if_stall_req !== 1'b0 || inst_out !== 32'h00100093) begin
      bad++;
      $display("FAIL cold_hit got=%b/%h exp=0/00100093", if_stall_req,
               inst_out);
    end
    total++;
    if (pc_out !== 32'h0 || branch_taken_out !== 1'b0) begin
      bad++;
      $display("FAIL cold_pc got=%h/%b exp=0/0", pc_out, branch_taken_out);
    end
  endtask

  task automatic test_stall_hold();
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (if_stall_req !== 1'b0 || mem_req !== 1'b0 || pc_out !== 32'h0 ||
          inst_out !== 32'h00100093) begin
        bad++;
        $display("FAIL hold%0d got=%b/%b/%h/%h exp=0/0/0/00100093", i,
                 if_stall_req, mem_req, pc_out, inst_out);
      end
    end
    stall_in = 6'd0;
    step();
    stall_in = 6'd1;
    total++;
    if (pc_out !== 32'h4 || if_stall_req !== 1'b1) begin
      bad++;
      $display("FAIL seq_next got=%h/%b exp=4/1", pc_out, if_stall_req);
    end
  endtask

  task automatic test_branch();
    jump_to(32'h10);
    wait_hit("br_fill");
    total++;
    if (inst_out !== 32'h00000463 || branch_taken_out !== 1'b0) begin
      bad++;
      $display("FAIL br_cnt1 got=%h/%b exp=00000463/0", inst_out,
               branch_taken_out);
    end
    bp_update_en = 1'b1;
    bp_update_pc = 32'h10;
    bp_update_taken = 1'b1;
    step();
    bp_update_en = 1'b0;
    total++;
    if (branch_taken_out !== 1'b1) begin
      bad++;
      $display("FAIL br_cnt2 got=%b exp=1", branch_taken_out);
    end
    stall_in = 6'd0;
    step();
    stall_in = 6'd1;
    total++;
    if (pc_out !== 32'h18) begin
      bad++;
      $display("FAIL br_target got=%h exp=18", pc_out);
    end
    jump_to(32'h10);
    bp_update_en = 1'b1;
    bp_update_taken = 1'b0;
    #1;
    total++;
    if (branch_taken_out !== 1'b1 || if_stall_req !== 1'b0) begin
      bad++;
      $display("FAIL br_old_value got=%b/%b exp=1/0", branch_taken_out,
               if_stall_req);
    end
    step();
    step();
    bp_update_en = 1'b0;
    total++;
    if (branch_taken_out !== 1'b0) begin
      bad++;
      $display("FAIL br_cnt0 got=%b exp=0", branch_taken_out);
    end
    stall_in = 6'd0;
    step();
    stall_in = 6'd1;
    total++;
    if (pc_out !== 32'h14) begin
      bad++;
      $display("FAIL br_fallthru got=%h exp=14", pc_out);
    end
    jump_to(32'h10);
    bp_update_en = 1'b1;
    bp_update_taken = 1'b0;
    step();
    bp_update_en = 1'b0;
    total++;
    if (branch_taken_out !== 1'b0) begin
      bad++;
      $display("FAIL br_sat0 got=%b exp=0", branch_taken_out);
    end
    bp_update_en = 1'b1;
    bp_update_taken = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bp_update_en = 1'b0;
    total++;
    if (branch_taken_out !== 1'b1) begin
      bad++;
      $display("FAIL br_sat3 got=%b exp=1", branch_taken_out);
    end
  endtask

  task automatic test_jal();
    jump_to(32'h20);
    wait_hit("jal_fill");
    total++;
    if (inst_out !== 32'hFF1FF06F || branch_taken_out !== 1'b1 ||
        pc_out !== 32'h20) begin
      bad++;
      $display("FAIL jal_hit got=%h/%b/%h exp=ff1ff06f/1/20", inst_out,
               branch_taken_out, pc_out);
    end
    stall_in = 6'd0;
    step();
    stall_in = 6'd1;
    total++;
    if (pc_out !== 32'h10 || if_stall_req !== 1'b0) begin
      bad++;
      $display("FAIL jal_target got=%h/%b exp=10/0", pc_out, if_stall_req);
    end
  endtask

  task automatic test_jump_in_wait();
    int c = 0;
    jump_to(32'h40);
    step();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      bad++;
      $display("FAIL jw_req got=%b/%h exp=1/40", mem_req, mem_addr);
    end
    jump_to(32'h100);
    total++;
    if (pc_out !== 32'h100 || mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      bad++;
      $display("FAIL jw_redirect got=%h/%b/%h exp=100/1/40", pc_out,
               mem_req, mem_addr);
    end
    while (mem_req && c < 40) begin
      step();
      c++;
    end
    total++;
    if (mem_req !== 1'b0 || if_stall_req !== 1'b1) begin
      bad++;
      $display("FAIL jw_done got=%b/%b exp=0/1", mem_req, if_stall_req);
    end
    step();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      bad++;
      $display("FAIL jw_newreq got=%b/%h exp=1/100", mem_req, mem_addr);
    end
    wait_hit("jw_fill");
    total++;
    if (inst_out !== 32'h00000013 || pc_out !== 32'h100) begin
      bad++;
      $display("FAIL jw_hit got=%h/%h exp=00000013/100", inst_out, pc_out);
    end
    jump_to(32'h40);
    total++;
    if (if_stall_req !== 1'b0 || inst_out !== 32'h00500113 ||
        mem_req !== 1'b0) begin
      bad++;
      $display("FAIL jw_line40 got=%b/%h/%b exp=0/00500113/0",
               if_stall_req, inst_out, mem_req);
    end
  endtask

  task automatic test_rdy_freeze();
    auto_mem = 1'b0;
    jump_to(32'h80);
    step();
    rdy_in = 1'b0;
    mem_ready = 1'b1;
    mem_inst = 32'hDEADBEEF;
    jump_enable = 1'b1;
    jump_addr = 32'h200;
    step();
    step();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h80 || if_stall_req !== 1'b1 ||
        pc_out !== 32'h80) begin
      bad++;
      $display("FAIL rdy_frozen got=%b/%h/%b/%h exp=1/80/1/80", mem_req,
               mem_addr, if_stall_req, pc_out);
    end
    rdy_in = 1'b1;
    mem_ready = 1'b0;
    jump_enable = 1'b0;
    step();
    total++;
    if (mem_req !== 1'b1 || if_stall_req !== 1'b1) begin
      bad++;
      $display("FAIL rdy_nofill got=%b/%b exp=1/1", mem_req, if_stall_req);
    end
    mem_ready = 1'b1;
    mem_inst = 32'h00A00193;
    step();
    mem_ready = 1'b0;
    total++;
    if (if_stall_req !== 1'b0 || inst_out !== 32'h00A00193 ||
        mem_req !== 1'b0) begin
      bad++;
      $display("FAIL rdy_fill got=%b/%h/%b exp=0/00a00193/0", if_stall_req,
               inst_out, mem_req);
    end
    stall_in = 6'd0;
    rdy_in = 1'b0;
    step();
    rdy_in = 1'b1;
    stall_in = 6'd1;
    total++;
    if (pc_out !== 32'h80) begin
      bad++;
      $display("FAIL rdy_pc_hold got=%h exp=80", pc_out);
    end
  endtask

  task automatic test_reset_mid_wait();
    jump_to(32'hC0);
    step();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'hC0) begin
      bad++;
      $display("FAIL rw_req got=%b/%h exp=1/c0", mem_req, mem_addr);
    end
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    total++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || pc_out !== 32'h0 ||
        if_stall_req !== 1'b1) begin
      bad++;
      $display("FAIL rw_reset got=%b/%h/%h/%b exp=0/0/0/1", mem_req,
               mem_addr, pc_out, if_stall_req);
    end
    mem_ready = 1'b1;
    mem_inst = 32'hBAD0BAD0;
    step();
    mem_ready = 1'b0;
    step();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || if_stall_req !== 1'b1) begin
      bad++;
      $display("FAIL rw_stale got=%b/%h/%b exp=1/0/1", mem_req, mem_addr,
               if_stall_req);
    end
    mem_ready = 1'b1;
    mem_inst = 32'h00100093;
    step();
    mem_ready = 1'b0;
    total++;
    if (if_stall_req !== 1'b0 || inst_out !== 32'h00100093) begin
      bad++;
      $display("FAIL rw_refill got=%b/%h exp=0/00100093", if_stall_req,
               inst_out);
    end
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    stall_in = 6'd1;
    jump_enable = 1'b0;
    jump_addr = 32'd0;
    bp_update_en = 1'b0;
    bp_update_pc = 32'd0;
    bp_update_taken = 1'b0;
    mem_ready = 1'b0;
    mem_inst = 32'd0;
    test_reset();
    test_cold_start();
    test_stall_hold();
    test_branch();
    test_jal();
    test_jump_in_wait();
    test_rdy_freeze();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
